// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_timing_gen                                                |
// | Purpose  : Parametrised VGA sync/timing master with a mode-selectable    |
// |            2-bit-per-channel test pattern. Runs on a single clock and    |
// |            advances only on cycles qualified by pix_en.                  |
// | Revision : 1.0 - first parametrised release (replaces fixed 640x400)    |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk          in   1   system clock                                     |
// |   rst          in   1   synchronous active-high reset                    |
// |   pix_en       in   1   pixel-clock enable                               |
// |   vga_state    in   2   pattern select, latched on entry to (0,0)        |
// |   x, y         out  CW  current pixel position                           |
// |   hsync/vsync  out  1   syncs, polarity set by H_SYNC_POL / V_SYNC_POL   |
// |   display_en   out  1   (x,y) inside visible area                        |
// |   vga_r/g/b    out  2   pattern colour, 0 outside visible area           |
// |   line_start   out  1   one-clk strobe when x becomes 0                  |
// |   frame_start  out  1   one-clk strobe when (x,y) becomes (0,0)          |
// |   frame_count  out  8   frames started since reset (wraps)               |
// +--------------------------------------------------------------------------+
// | Every porch and pulse width must be at least 1, and CW must be at least  |
// | 9 so the colour-bar index x[8:6] exists.                                 |
// +--------------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_PULSE    = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 400,
  parameter int V_FRONT    = 12,
  parameter int V_PULSE    = 2,
  parameter int V_BACK     = 35,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b1,
  parameter int CW         = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic [1:0]    vga_state,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          display_en,
  output logic [1:0]    vga_r,
  output logic [1:0]    vga_g,
  output logic [1:0]    vga_b,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_PULSE + V_BACK;

  // First coordinate of each region, and the last coordinate of a line/frame.
  localparam logic [CW-1:0] c_H_FP_X = CW'(H_VISIBLE);
  localparam logic [CW-1:0] c_H_SP_X = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] c_H_BP_X = CW'(H_VISIBLE + H_FRONT + H_PULSE);
  localparam logic [CW-1:0] c_H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] c_V_FP_Y = CW'(V_VISIBLE);
  localparam logic [CW-1:0] c_V_SP_Y = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] c_V_BP_Y = CW'(V_VISIBLE + V_FRONT + V_PULSE);
  localparam logic [CW-1:0] c_V_LAST = CW'(V_TOTAL - 1);

  // Horizontal and vertical region encodings
  localparam logic [1:0] H_VIS = 2'd0;
  localparam logic [1:0] H_FP  = 2'd1;
  localparam logic [1:0] H_SP  = 2'd2;
  localparam logic [1:0] H_BP  = 2'd3;
  localparam logic [1:0] V_VIS = 2'd0;
  localparam logic [1:0] V_FP  = 2'd1;
  localparam logic [1:0] V_SP  = 2'd2;
  localparam logic [1:0] V_BP  = 2'd3;

  // Registered state and outputs
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic [1:0]    r_h_state;
  logic [1:0]    r_v_state;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_display_en;
  logic [1:0]    r_vga_r;
  logic [1:0]    r_vga_g;
  logic [1:0]    r_vga_b;
  logic          r_line_start;
  logic          r_frame_start;
  logic [7:0]    r_frame_count;
  logic [1:0]    r_mode;

  // Next-position decode
  logic          w_x_wrap;
  logic          w_y_wrap;
  logic          w_frame_wrap;
  logic [CW-1:0] w_x_next;
  logic [CW-1:0] w_y_next;
  logic [7:0]    w_fc_next;
  logic [1:0]    w_mode_next;
  logic [1:0]    w_h_state_next;
  logic [1:0]    w_v_state_next;

  // Next output values
  logic          w_hsync_next;
  logic          w_vsync_next;
  logic          w_de_next;
  logic          w_checker;
  logic [1:0]    w_r_next;
  logic [1:0]    w_g_next;
  logic [1:0]    w_b_next;

  // ---------------------------------------------------------------------
  // Position counters one pix_en step ahead
  // ---------------------------------------------------------------------
  assign w_x_wrap     = (r_x == c_H_LAST);
  assign w_y_wrap     = (r_y == c_V_LAST);
  assign w_frame_wrap = w_x_wrap & w_y_wrap;

  assign w_x_next  = w_x_wrap ? '0 : r_x + CW'(1);
  assign w_y_next  = !w_x_wrap ? r_y : (w_y_wrap ? '0 : r_y + CW'(1));
  assign w_fc_next = w_frame_wrap ? r_frame_count + 8'd1 : r_frame_count;

  // The pattern mode only changes on the step that enters (0,0), so the
  // whole frame, including its first pixel, is drawn in one mode.
  assign w_mode_next = w_frame_wrap ? vga_state : r_mode;

  // ---------------------------------------------------------------------
  // State register (process 1 of 3): all outputs load together so that
  // syncs and colour always describe the same (x,y) as the coordinates.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x           <= c_H_LAST;
      r_y           <= c_V_LAST;
      r_h_state     <= H_BP;
      r_v_state     <= V_BP;
      r_hsync       <= ~H_SYNC_POL;
      r_vsync       <= ~V_SYNC_POL;
      r_display_en  <= 1'b0;
      r_vga_r       <= 2'b00;
      r_vga_g       <= 2'b00;
      r_vga_b       <= 2'b00;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'hFF;
      r_mode        <= 2'd0;
    end else begin
      // Strobes last one clk regardless of pix_en.
      r_line_start  <= pix_en & w_x_wrap;
      r_frame_start <= pix_en & w_frame_wrap;
      if (pix_en) begin
        r_x           <= w_x_next;
        r_y           <= w_y_next;
        r_h_state     <= w_h_state_next;
        r_v_state     <= w_v_state_next;
        r_hsync       <= w_hsync_next;
        r_vsync       <= w_vsync_next;
        r_display_en  <= w_de_next;
        r_vga_r       <= w_r_next;
        r_vga_g       <= w_g_next;
        r_vga_b       <= w_b_next;
        r_frame_count <= w_fc_next;
        r_mode        <= w_mode_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic (process 2 of 3): each region is left when the next
  // coordinate reaches the first coordinate of the following region.
  // The vertical FSM can only move on the step where x wraps.
  // ---------------------------------------------------------------------
  always_comb begin
    w_h_state_next = r_h_state;
    case (r_h_state)
      H_VIS:   if (w_x_next == c_H_FP_X) w_h_state_next = H_FP;
      H_FP:    if (w_x_next == c_H_SP_X) w_h_state_next = H_SP;
      H_SP:    if (w_x_next == c_H_BP_X) w_h_state_next = H_BP;
      default: if (w_x_wrap)             w_h_state_next = H_VIS;
    endcase
  end

  always_comb begin
    w_v_state_next = r_v_state;
    if (w_x_wrap) begin
      case (r_v_state)
        V_VIS:   if (w_y_next == c_V_FP_Y) w_v_state_next = V_FP;
        V_FP:    if (w_y_next == c_V_SP_Y) w_v_state_next = V_SP;
        V_SP:    if (w_y_next == c_V_BP_Y) w_v_state_next = V_BP;
        default: if (w_y_wrap)             w_v_state_next = V_VIS;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output logic (process 3 of 3): decoded from the next state/position.
  // ---------------------------------------------------------------------
  always_comb begin
    w_hsync_next = (w_h_state_next == H_SP) ? H_SYNC_POL : ~H_SYNC_POL;
    w_vsync_next = (w_v_state_next == V_SP) ? V_SYNC_POL : ~V_SYNC_POL;
    w_de_next    = (w_h_state_next == H_VIS) && (w_v_state_next == V_VIS);
  end

  // Checker cell bit is bit 5 of (x + frame_count); only the low six bits
  // of each operand can influence it, so a 6-bit modular sum suffices.
  assign w_checker = ((w_x_next[5:0] + w_fc_next[5:0]) >= 6'd32) ^ w_y_next[5];

  always_comb begin
    w_r_next = 2'b00;
    w_g_next = 2'b00;
    w_b_next = 2'b00;
    if (w_de_next) begin
      case (w_mode_next)
        2'd1: begin
          w_r_next = 2'b11;
          w_g_next = 2'b11;
          w_b_next = 2'b11;
        end
        2'd2: begin
          // 64-pixel bars, bar index = x[8:6]
          w_r_next = {2{w_x_next[8]}};
          w_g_next = {2{w_x_next[7]}};
          w_b_next = {2{w_x_next[6]}};
        end
        2'd3: begin
          w_r_next = {2{w_checker}};
          w_g_next = {2{w_checker}};
          w_b_next = {2{w_checker}};
        end
        default: begin
          // mode 0: black
          w_r_next = 2'b00;
          w_g_next = 2'b00;
          w_b_next = 2'b00;
        end
      endcase
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_en  = r_display_en;
  assign vga_r       = r_vga_r;
  assign vga_g       = r_vga_g;
  assign vga_b       = r_vga_b;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vga_timing_gen                                             |
// | Purpose  : Self-checking bench for vga_timing_gen. Full 800-pixel lines, |
// |            short 12-line frames so whole frames fit in a short run.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_vga_timing_gen;

  localparam int HV = 640, HF = 16, HP = 96, HB = 48;
  localparam int VV = 6,   VF = 2,  VP = 2,  VB = 2;
  localparam int HT = HV + HF + HP + HB;   // 800
  localparam int VT = VV + VF + VP + VB;   // 12
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;

  logic        clk;
  logic        rst;
  logic        pix_en;
  logic [1:0]  vga_state;
  logic [10:0] x;
  logic [10:0] y;
  logic        hsync;
  logic        vsync;
  logic        display_en;
  logic [1:0]  vga_r;
  logic [1:0]  vga_g;
  logic [1:0]  vga_b;
  logic        line_start;
  logic        frame_start;
  logic [7:0]  frame_count;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
    .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .CW(11)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .vga_state(vga_state),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync), .display_en(display_en),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain position arithmetic
  int mx, my, mfc, mmode;
  bit mls, mfs;

  typedef struct {
    logic        r;
    logic        en;
    logic [1:0]  vs;
    logic [10:0] ex;
    logic [10:0] ey;
    logic        ehs;
    logic        evs;
    logic        ede;
    logic [5:0]  ergb;
    logic        els;
    logic        efs;
    logic [7:0]  efc;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [40:0] dut_vec();
    return {x, y, hsync, vsync, display_en, vga_r, vga_g, vga_b,
            line_start, frame_start, frame_count};
  endfunction

  function automatic logic [40:0] model_vec();
    logic       hs, vs, de, c;
    logic [1:0] rr, gg, bb;
    int         idx;
    hs = (mx >= HV + HF && mx < HV + HF + HP) ? HPOL : !HPOL;
    vs = (my >= VV + VF && my < VV + VF + VP) ? VPOL : !VPOL;
    de = (mx < HV) && (my < VV);
    rr = 2'b00; gg = 2'b00; bb = 2'b00;
    if (de) begin
      case (mmode)
        1: begin rr = 2'b11; gg = 2'b11; bb = 2'b11; end
        2: begin
          idx = (mx / 64) % 8;
          rr = (idx >= 4) ? 2'b11 : 2'b00;
          gg = ((idx / 2) % 2 == 1) ? 2'b11 : 2'b00;
          bb = (idx % 2 == 1) ? 2'b11 : 2'b00;
        end
        3: begin
          c  = (((mx + mfc) / 32) % 2) != ((my / 32) % 2);
          rr = {2{c}}; gg = {2{c}}; bb = {2{c}};
        end
        default: ;
      endcase
    end
    return {11'(mx), 11'(my), hs, vs, de, rr, gg, bb, mls, mfs, 8'(mfc)};
  endfunction

  // One clk: apply inputs, advance the model, compare every output.
  task automatic step(input logic r, input logic en, input logic [1:0] vs);
    rst = r; pix_en = en; vga_state = vs;
    @(posedge clk);
    #1;
    if (r) begin
      mx = HT - 1; my = VT - 1; mfc = 255; mmode = 0; mls = 0; mfs = 0;
    end else begin
      mls = 0; mfs = 0;
      if (en) begin
        mx = (mx + 1) % HT;
        if (mx == 0) begin
          mls = 1;
          my  = (my + 1) % VT;
          if (my == 0) begin
            mfs   = 1;
            mfc   = (mfc + 1) % 256;
            mmode = int'(vs);
          end
        end
      end
    end
    chk("model", 64'(dut_vec()), 64'(model_vec()));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit expired before end of test");
    $fatal(1, "watchdog");
  end

  int  hs_low, first_low, de_cnt, ls_hits, vs_cnt, de_bad, vs_bad, nonwhite, wide;
  bit  got, prev_ls, prev_fs;

  initial begin
    rst = 1'b1; pix_en = 1'b0; vga_state = 2'd0;
    mx = 0; my = 0; mfc = 0; mmode = 0; mls = 0; mfs = 0;

    // ---------------- table-driven vectors ----------------
    //            r    en   vs    x        y      hs   vs   de   rgb     ls   fs   fc
    tbl[0] = '{1'b1,1'b0,2'd0,11'd799,11'd11,1'b1,1'b0,1'b0,6'h00,1'b0,1'b0,8'hFF};
    tbl[1] = '{1'b0,1'b1,2'd2,11'd0,  11'd0, 1'b1,1'b0,1'b1,6'h00,1'b1,1'b1,8'h00};
    tbl[2] = '{1'b0,1'b0,2'd1,11'd0,  11'd0, 1'b1,1'b0,1'b1,6'h00,1'b0,1'b0,8'h00};
    tbl[3] = '{1'b0,1'b1,2'd1,11'd1,  11'd0, 1'b1,1'b0,1'b1,6'h00,1'b0,1'b0,8'h00};
    tbl[4] = '{1'b0,1'b1,2'd0,11'd2,  11'd0, 1'b1,1'b0,1'b1,6'h00,1'b0,1'b0,8'h00};
    tbl[5] = '{1'b1,1'b1,2'd3,11'd799,11'd11,1'b1,1'b0,1'b0,6'h00,1'b0,1'b0,8'hFF};
    tbl[6] = '{1'b0,1'b1,2'd1,11'd0,  11'd0, 1'b1,1'b0,1'b1,6'h3F,1'b1,1'b1,8'h00};
    tbl[7] = '{1'b0,1'b0,2'd0,11'd0,  11'd0, 1'b1,1'b0,1'b1,6'h3F,1'b0,1'b0,8'h00};
    tbl[8] = '{1'b0,1'b1,2'd0,11'd1,  11'd0, 1'b1,1'b0,1'b1,6'h3F,1'b0,1'b0,8'h00};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].en, tbl[i].vs);
      chk($sformatf("table[%0d]", i), 64'(dut_vec()),
          64'({tbl[i].ex, tbl[i].ey, tbl[i].ehs, tbl[i].evs, tbl[i].ede,
               tbl[i].ergb, tbl[i].els, tbl[i].efs, tbl[i].efc}));
    end

    // ---------------- first line from reset, colour bars ----------------
    step(1'b1, 1'b0, 2'd2);
    hs_low = 0; first_low = -1; de_cnt = 0; ls_hits = 0;
    for (int i = 1; i <= 801; i++) begin
      step(1'b0, 1'b1, 2'd2);
      if (line_start) ls_hits++;
      if (i == 1 || i == 801) chk($sformatf("line_start@clk%0d", i), 64'(line_start), 64'd1);
      if (i <= 800) begin
        if (!hsync) begin
          hs_low++;
          if (first_low < 0) first_low = int'(x);
        end
        if (display_en) de_cnt++;
      end
      if (y == 0 && (x == 0 || x == 63))    chk("bar0_rgb", 64'({vga_r, vga_g, vga_b}), 64'h00);
      if (y == 0 && (x == 64 || x == 127))  chk("bar1_rgb", 64'({vga_r, vga_g, vga_b}), 64'h03);
      if (y == 0 && (x == 448 || x == 511)) chk("bar7_rgb", 64'({vga_r, vga_g, vga_b}), 64'h3F);
      if (y == 0 && x == 700)               chk("blank_rgb", 64'({vga_r, vga_g, vga_b}), 64'h00);
    end
    chk("y_after_line", 64'(y), 64'd1);
    chk("hsync_low_count", 64'(hs_low), 64'd96);
    chk("hsync_first_x", 64'(first_low), 64'd656);
    chk("display_en_count", 64'(de_cnt), 64'd640);
    chk("line_start_count", 64'(ls_hits), 64'd2);

    // ---------------- rest of the frame ----------------
    vs_cnt = 0; de_bad = 0; vs_bad = 0; got = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      step(1'b0, 1'b1, 2'd1);
      if (vsync) begin
        vs_cnt++;
        if (y < VV + VF || y >= VV + VF + VP) vs_bad++;
      end
      if (display_en && y >= VV) de_bad++;
      if (frame_start) got = 1;
    end
    chk("frame1_reached", 64'(got), 64'd1);
    chk("frame_count_1", 64'(frame_count), 64'd1);
    chk("vsync_cycles", 64'(vs_cnt), 64'(VP * HT));
    chk("vsync_outside", 64'(vs_bad), 64'd0);
    chk("de_below_visible", 64'(de_bad), 64'd0);

    // ---------------- mode change mid-frame (white -> black) ----------------
    nonwhite = 0; got = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      step(1'b0, 1'b1, (my >= 3) ? 2'd0 : 2'd1);
      if (frame_start) got = 1;
      else if (display_en && {vga_r, vga_g, vga_b} != 6'h3F) nonwhite++;
    end
    chk("frame2_reached", 64'(got), 64'd1);
    chk("white_whole_frame", 64'(nonwhite), 64'd0);
    chk("black_next_frame", 64'({display_en, vga_r, vga_g, vga_b}), 64'h40);

    // ---------------- pix_en every 3rd clk ----------------
    prev_ls = 0; prev_fs = 0; wide = 0;
    for (int i = 0; i < 5100; i++) begin
      step(1'b0, (i % 3) == 0, 2'd3);
      if ((line_start && prev_ls) || (frame_start && prev_fs)) wide++;
      prev_ls = line_start; prev_fs = frame_start;
    end
    chk("strobe_width", 64'(wide), 64'd0);

    // ---------------- reset mid-frame ----------------
    got = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      if (mx == 300 && my == 2) got = 1;
      else step(1'b0, 1'b1, 2'd3);
    end
    chk("reach_300_2", 64'(got), 64'd1);
    step(1'b1, 1'b1, 2'd3);
    chk("rst_x", 64'(x), 64'd799);
    chk("rst_y", 64'(y), 64'(VT - 1));
    chk("rst_fc", 64'(frame_count), 64'd255);
    chk("rst_syncs", 64'({hsync, vsync}), 64'({!HPOL, !VPOL}));
    step(1'b0, 1'b1, 2'd3);
    chk("post_rst_pos", 64'({x, y}), 64'd0);
    chk("post_rst_fs", 64'(frame_start), 64'd1);

    // ---------------- randomized run against the model ----------------
    for (int i = 0; i < 15000; i++) begin
      step($urandom_range(0, 4999) == 0, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
